svnseg_scan_display: RTL and testbench

- Downstream consumer of uart_receiver.
- Captures each received byte on data_valid and keeps the two most recent bytes as four hex nibbles.
- Time-multiplexes the nibbles across all four digits of the 7-segment display.
- Replaces the static single-digit drive in the board top level; outputs connect directly to the SVNSEG_DIGx/SVNSEG_SEGx pins.

---
 rtl/svnseg_pkg.sv | 21 ++
 rtl/num_to_7seg.sv | 33 +++
 rtl/svnseg_scan_display.sv | 124 ++++++++++++
 tb/tb_svnseg_scan_display.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/svnseg_pkg.sv
// svnseg_pkg: shared types and constants for the scanned 7-segment display.
//   digit_idx_t  - index of the currently scanned digit (0 = rightmost).
//   DIG_OFF      - all digit enables inactive (active-low).
//   SEG_BLANK    - all segments off (active-low).
//   DP_DIGIT     - digit whose decimal point separates the two bytes.
//   digit_loaded - whether a digit's byte has arrived, given the load count.
`timescale 1ns/1ps
package svnseg_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [3:0] DIG_OFF   = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam digit_idx_t DP_DIGIT  = 2'd2;

    // Digits 0-1 hold the newest byte, digits 2-3 the previous one.
    function automatic logic digit_loaded(input digit_idx_t idx, input logic [1:0] loaded);
        return idx[1] ? (loaded == 2'd2) : (loaded != 2'd0);
    endfunction

endpackage

// File: rtl/num_to_7seg.sv
// num_to_7seg: existing board hex-to-segment decoder.
//   in  [3:0] - hex nibble.
//   out [6:0] - active-low segments, out[6]=a .. out[0]=g.
`timescale 1ns/1ps
module num_to_7seg (
    input  logic [3:0] in,
    output logic [6:0] out
);

    always_comb begin
        out = 7'b1111111;
        case (in)
            4'h0: out = 7'b0000001;
            4'h1: out = 7'b1001111;
            4'h2: out = 7'b0010010;
            4'h3: out = 7'b0000110;
            4'h4: out = 7'b1001100;
            4'h5: out = 7'b0100100;
            4'h6: out = 7'b0100000;
            4'h7: out = 7'b0001111;
            4'h8: out = 7'b0000000;
            4'h9: out = 7'b0000100;
            4'hA: out = 7'b0001000;
            4'hB: out = 7'b1100000;
            4'hC: out = 7'b0110001;
            4'hD: out = 7'b1000010;
            4'hE: out = 7'b0110000;
            4'hF: out = 7'b0111000;
            default: out = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/svnseg_scan_display.sv
// svnseg_scan_display: keeps the two most recent UART bytes and scans their
// four hex nibbles across the 4-digit 7-segment display.
//   clk, rst         - clock, asynchronous active-high reset.
//   data_valid, data - byte strobe and byte from uart_receiver.
//   dig [3:0]        - active-low digit enables, dig[0] = rightmost.
//   seg [6:0]        - active-low segments, seg[6]=a .. seg[0]=g.
//   dp               - active-low decimal point (lit on digit 2).
// Optional macro SVNSEG_UNLOADED_BLANK_EN: digits whose byte has not yet been
// received since reset stay dark during their drive phase.
`timescale 1ns/1ps
module svnseg_scan_display
    import svnseg_pkg::*;
#(
    parameter int unsigned REFRESH_CLKS = 25000,
    parameter int unsigned BLANK_CLKS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic [7:0] data,
    output logic [3:0] dig,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CNT_W = (REFRESH_CLKS > 1) ? $clog2(REFRESH_CLKS) : 1;

    logic [15:0]      r_history;
    logic [CNT_W-1:0] r_slot_cnt;
    digit_idx_t       r_idx;
    logic [3:0]       r_dig;
    logic [6:0]       r_seg;
    logic             r_dp;
`ifdef SVNSEG_UNLOADED_BLANK_EN
    logic [1:0]       r_loaded;
`endif

    logic [3:0] w_nibble;
    logic [6:0] w_seg_hex;
    logic       w_drive;
    logic       w_lit;
    logic [3:0] w_dig_nxt;
    logic [6:0] w_seg_nxt;
    logic       w_dp_nxt;

    // Byte capture and scan counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_history  <= 16'h0000;
            r_slot_cnt <= '0;
            r_idx      <= 2'd0;
`ifdef SVNSEG_UNLOADED_BLANK_EN
            r_loaded   <= 2'd0;
`endif
        end else begin
            if (data_valid) begin
                r_history <= {r_history[7:0], data};
`ifdef SVNSEG_UNLOADED_BLANK_EN
                if (r_loaded != 2'd2) r_loaded <= r_loaded + 2'd1;
`endif
            end
            if (r_slot_cnt == CNT_W'(REFRESH_CLKS - 1)) begin
                r_slot_cnt <= '0;
                r_idx      <= r_idx + 2'd1;
            end else begin
                r_slot_cnt <= r_slot_cnt + CNT_W'(1);
            end
        end
    end

    // Nibble select for the scanned digit.
    always_comb begin
        w_nibble = 4'h0;
        case (r_idx)
            2'd0:    w_nibble = r_history[3:0];
            2'd1:    w_nibble = r_history[7:4];
            2'd2:    w_nibble = r_history[11:8];
            default: w_nibble = r_history[15:12];
        endcase
    end

    num_to_7seg u_hex (
        .in  (w_nibble),
        .out (w_seg_hex)
    );

    // Output phase decode: blank at slot start, then drive the selected digit.
    always_comb begin
        w_dig_nxt = DIG_OFF;
        w_seg_nxt = SEG_BLANK;
        w_dp_nxt  = 1'b1;
        w_drive   = (r_slot_cnt >= CNT_W'(BLANK_CLKS));
`ifdef SVNSEG_UNLOADED_BLANK_EN
        w_lit     = w_drive && digit_loaded(r_idx, r_loaded);
`else
        w_lit     = w_drive;
`endif
        if (w_drive) begin
            w_dig_nxt = ~(4'b0001 << r_idx);
        end
        if (w_lit) begin
            w_seg_nxt = w_seg_hex;
            w_dp_nxt  = (r_idx != DP_DIGIT);
        end
    end

    // Registered pin drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dig <= DIG_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_dig <= w_dig_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign dig = r_dig;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_svnseg_scan_display.sv
// tb_svnseg_scan_display: directed self-checking bench for svnseg_scan_display
// with REFRESH_CLKS=20, BLANK_CLKS=3. Honours SVNSEG_UNLOADED_BLANK_EN.
`timescale 1ns/1ps
module tb_svnseg_scan_display;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S5 = 7'b0100100, S7 = 7'b0001111,
                           SA = 7'b0001000, SC = 7'b0110001, SE = 7'b0110000,
                           SOFF = 7'b1111111;

    logic       clk;
    logic       rst;
    logic       data_valid;
    logic [7:0] data;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;

    int tests = 0;
    int fails = 0;

    svnseg_scan_display #(.REFRESH_CLKS(20), .BLANK_CLKS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data       (data),
        .dig        (dig),
        .seg        (seg),
        .dp         (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk_dig(input string tag, input logic [3:0] exp);
        tests++;
        assert (dig === exp) else begin
            fails++;
            $error("FAIL %s: dig observed %b expected %b", tag, dig, exp);
        end
    endtask

    task automatic chk_seg(input string tag, input logic [6:0] exp);
        tests++;
        assert (seg === exp) else begin
            fails++;
            $error("FAIL %s: seg observed %b expected %b", tag, seg, exp);
        end
    endtask

    task automatic chk_dp(input string tag, input logic exp);
        tests++;
        assert (dp === exp) else begin
            fails++;
            $error("FAIL %s: dp observed %b expected %b", tag, dp, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance on negedges until (dig == pat) equals eq; timeout counts as a failure.
    task automatic wait_dig(input string tag, input logic [3:0] pat, input bit eq);
        int n = 0;
        while (((dig === pat) != eq) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if ((dig === pat) != eq) begin
            tests++;
            fails++;
            $error("FAIL %s: timeout waiting for dig %s %b, observed %b",
                   tag, eq ? "==" : "!=", pat, dig);
        end
    endtask

    task automatic check_digit(input string tag, input logic [3:0] pat,
                               input logic [6:0] exp_seg, input logic exp_dp);
        wait_dig(tag, pat, 1'b1);
        chk_seg(tag, exp_seg);
        chk_dp(tag, exp_dp);
    endtask

    task automatic send(input logic [7:0] b);
        data_valid = 1'b1;
        data       = b;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] pats [4];
        int cnt;
        pats = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        rst = 1'b1; data_valid = 1'b0; data = 8'h00;
        #2;
        chk_dig("rst_dig", 4'b1111);
        chk_seg("rst_seg", SOFF);
        chk_dp("rst_dp", 1'b1);
        @(negedge clk); @(negedge clk);
        chk_dig("rst_hold_dig", 4'b1111);
        rst = 1'b0;

        // Empty history after reset.
`ifdef SVNSEG_UNLOADED_BLANK_EN
        check_digit("post_rst_d0", 4'b1110, SOFF, 1'b1);
`else
        check_digit("post_rst_d0", 4'b1110, S0, 1'b1);
`endif

        // Single byte 8'h7E.
        send(8'h7E);
        @(negedge clk);
        check_digit("one_d0", 4'b1110, SE, 1'b1);
        check_digit("one_d1", 4'b1101, S7, 1'b1);
`ifdef SVNSEG_UNLOADED_BLANK_EN
        check_digit("one_d2", 4'b1011, SOFF, 1'b1);
        check_digit("one_d3", 4'b0111, SOFF, 1'b1);
`else
        check_digit("one_d2", 4'b1011, S0, 1'b0);
        check_digit("one_d3", 4'b0111, S0, 1'b1);
`endif

        // History ABCD, then asynchronous reset during digit1 drive.
        send(8'hAB);
        send(8'hCD);
        @(negedge clk);
        check_digit("abcd_d1", 4'b1101, SC, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_dig("async_rst_dig", 4'b1111);
        chk_seg("async_rst_seg", SOFF);
        chk_dp("async_rst_dp", 1'b1);
        @(negedge clk);
        rst = 1'b0;
`ifdef SVNSEG_UNLOADED_BLANK_EN
        check_digit("rst2_d0", 4'b1110, SOFF, 1'b1);
`else
        check_digit("rst2_d0", 4'b1110, S0, 1'b1);
`endif

        // Two captures: history A53C.
        send(8'hA5);
        send(8'h3C);
        @(negedge clk);
        check_digit("a53c_d0", 4'b1110, SC, 1'b1);
        check_digit("a53c_d1", 4'b1101, S3, 1'b1);
        check_digit("a53c_d2", 4'b1011, S5, 1'b0);
        check_digit("a53c_d3", 4'b0111, SA, 1'b1);

        // Scan timing: 17 drive cycles then 3 blank cycles per digit.
        wait_dig("sync_d3", 4'b0111, 1'b1);
        wait_dig("sync_blank", 4'b1111, 1'b1);
        wait_dig("sync_start", 4'b1111, 1'b0);
        chk_dig("scan_start", 4'b1110);
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            while (dig === pats[k] && cnt < 40) begin
                cnt++;
                @(negedge clk);
            end
            chk_int($sformatf("drive_len_%0d", k), cnt, 17);
            cnt = 0;
            while (dig === 4'b1111 && cnt < 40) begin
                cnt++;
                @(negedge clk);
            end
            chk_int($sformatf("blank_len_%0d", k), cnt, 3);
        end
        chk_dig("scan_wrap", 4'b1110);

        // Capture 8'h50 on the wrap edge from digit3 into digit0.
        wait_dig("wrap_d3", 4'b0111, 1'b1);
        repeat (15) @(negedge clk);
        chk_dig("wrap_pre", 4'b0111);
        send(8'h50);
        chk_dig("wrap_last", 4'b0111);
        @(negedge clk);
        chk_dig("wrap_blank", 4'b1111);
        check_digit("wrap_d0", 4'b1110, S0, 1'b1);
        check_digit("wrap_d1", 4'b1101, S5, 1'b1);
        check_digit("wrap_d2", 4'b1011, SC, 1'b0);
        check_digit("wrap_d3b", 4'b0111, S3, 1'b1);

        // Held strobe: three captures of 8'h12.
        data_valid = 1'b1;
        data       = 8'h12;
        repeat (3) @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
        check_digit("held_d0", 4'b1110, S2, 1'b1);
        check_digit("held_d1", 4'b1101, S1, 1'b1);
        check_digit("held_d2", 4'b1011, S2, 1'b0);
        check_digit("held_d3", 4'b0111, S1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
